peripheral_msi_master_port_ahb3: RTL and testbench
==================================================

Name: peripheral_msi_master_port_ahb3

Overview:
Per-master front end of the MSI AHB3-Lite interconnect; one instance sits between each AHB master and the array of MSI slave ports. It decodes the master's address against per-slave base/mask, requests the matching slave port, stalls the master while that slave port is granted to another master, and steers read data and responses from the slave port that owns the data phase. It also drives the can_switch indications the slave-port arbiters use, so that locked sequences and fixed-length bursts are never split.

Parameters:
PLEN, 64, address width
XLEN, 64, data width
SLAVES, 5, number of slave ports reached by this master

Ports:
HCLK  in  1  clock
HRESET  in  1  reset; synchronous, active-high
mstpriority  in  3  master priority level, forwarded unchanged
mstHSEL, mstHADDR[PLEN], mstHWDATA[XLEN], mstHWRITE, mstHSIZE[3], mstHBURST[3], mstHPROT[4], mstHTRANS[2], mstHMASTLOCK  in  -  AHB master address/data-phase signals
mstHRDATA  out  XLEN  read data from the data-phase slave
mstHREADYOUT  out  1  ready to master
mstHRESP  out  1  response to master
slvHADDR_MASK, slvHADDR_BASE  in  SLAVES x PLEN  decode window per slave port
slvpriority  out  3  = mstpriority
slvHSEL  out  SLAVES  one-hot request/select per slave port
slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST, slvHPROT, slvHTRANS, slvHMASTLOCK  out  -  broadcast command to all slave ports
slvHREADY  out  1  HREADY broadcast to slave ports (= mstHREADYOUT)
slvHRDATA  in  SLAVES x XLEN  per-port read data
slvHREADYOUT, slvHRESP  in  SLAVES  per-port ready/response
granted  in  SLAVES  bit s = slave port s currently grants this master
can_switch  out  SLAVES  bit s = slave port s may re-arbitrate away from this master

Behaviour:
- Decode: hit[s] = ((mstHADDR ^ slvHADDR_BASE[s]) & slvHADDR_MASK[s]) == 0. On multiple hits, the lowest index wins. active = mstHSEL && mstHTRANS is NONSEQ or SEQ.
- Accept: an address phase is accepted when mstHREADYOUT=1 and active.
- Reset values: state=NORMAL, mstHREADYOUT=1, mstHRESP=0, mstHRDATA=0, slvHSEL=0, data_slave=none, burst_cnt=0, lock_hold=0, can_switch=all ones, command buffer cleared.
- States:
  - NORMAL: slvHSEL=hit & {SLAVES{mstHSEL}}; command passed through combinationally (zero latency).
    - Accepted with target granted -> data_slave <= target; stay in NORMAL.
    - Accepted, target not granted -> latch command into buffer -> WAIT_GRANT.
    - Accepted with no hit -> ERR1.
    - IDLE/BUSY transfer: data_slave <= none.
  - WAIT_GRANT: slvHSEL=target, command sourced from buffer, slvHTRANS=IDLE until granted[target]. mstHREADYOUT=0, mstHRESP=0.
    - When granted[target] && slvHREADYOUT[target]: drive buffered command with SEQ forced to NONSEQ; data_slave <= target -> NORMAL.
  - ERR1: mstHREADYOUT=0, mstHRESP=1 -> ERR2.
  - ERR2: mstHREADYOUT=1, mstHRESP=1; a transfer presented in ERR2 is decoded and accepted as in NORMAL -> NORMAL.
- Data phase: in NORMAL, mstHRDATA/mstHREADYOUT/mstHRESP = slvHRDATA/slvHREADYOUT/slvHRESP[data_slave]. If data_slave=none: HREADYOUT=1, HRESP=0, HRDATA=0.
- Burst counter: an accepted NONSEQ loads 3/7/15 for INCR4/WRAP4, INCR8/WRAP8, INCR16/WRAP16, and 0 otherwise. Each accepted SEQ decrements it, saturating at 0. INCR (undefined length) sets incr_open, which clears on an accepted IDLE or a non-INCR NONSEQ.
- lock_hold <= mstHMASTLOCK of the last accepted transfer.
- Hold condition: hold = lock_hold | incr_open | (burst_cnt!=0). can_switch[s] = !(hold && data_slave==s).
- HRESET asserted mid-transfer: all state returns to reset values on the next edge; the buffered command is dropped.
- Simultaneous events: ERR1/ERR2 take precedence over new decode; a slave-port HRESP during a burst clears burst_cnt and incr_open.

Decomposition:
- Shared package peripheral_msi_ahb3_pkg: HTRANS/HBURST/HSIZE localparams (IDLE, BUSY, NONSEQ, SEQ, SINGLE … WRAP16) and the port state enum.
- Natural sub-module: peripheral_msi_address_decoder_ahb3 (combinational base/mask hit vector plus lowest-index one-hot select).

Test Plan:
- Reset, then idle: mstHREADYOUT=1, can_switch=5'b11111, slvHSEL=0.
- Single read to slave 2 (base 0x2000, mask 0xF000), granted[2]=1: slvHSEL=5'b00100 same cycle; mstHRDATA = slvHRDATA[2] in the next cycle.
- Same read with granted[2]=0 for 3 cycles: mstHREADYOUT=0 for 4 cycles. Buffered address reissued as NONSEQ when granted[2] rises; data returned correctly.
- Address 0xF000 with no hit: ERR1 gives HREADYOUT=0/HRESP=1, then ERR2 gives HREADYOUT=1/HRESP=1, then back to NORMAL.
- INCR4 write to slave 1: can_switch[1]=0 from acceptance of NONSEQ through third SEQ; returns to 1 after the last beat.
- HMASTLOCK single to slave 0 followed by unlocked IDLE: can_switch[0]=0 only while lock_hold=1. HRESET mid-WAIT_GRANT: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/peripheral_msi_master_port_ahb3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_msi_ahb3_pkg
// Purpose  : Shared AHB3-Lite encodings and master-port state type for the
//            MSI interconnect (HTRANS, HBURST, HSIZE, port FSM states) plus a
//            helper that converts a fixed-length burst type into the number
//            of SEQ beats still to follow the NONSEQ.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package peripheral_msi_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [2:0] HSIZE_B8      = 3'd0;
  localparam logic [2:0] HSIZE_B16     = 3'd1;
  localparam logic [2:0] HSIZE_B32     = 3'd2;
  localparam logic [2:0] HSIZE_B64     = 3'd3;

  typedef enum logic [1:0] {
    ST_NORMAL     = 2'd0,
    ST_WAIT_GRANT = 2'd1,
    ST_ERR1       = 2'd2,
    ST_ERR2       = 2'd3
  } port_state_t;

  // SEQ beats that follow the NONSEQ of a fixed-length burst.
  function automatic logic [3:0] burst_beats_left(input logic [2:0] hburst);
    case (hburst)
      HBURST_INCR4, HBURST_WRAP4:   return 4'd3;
      HBURST_INCR8, HBURST_WRAP8:   return 4'd7;
      HBURST_INCR16, HBURST_WRAP16: return 4'd15;
      default:                      return 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/peripheral_msi_master_port_ahb3_if.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_msi_master_port_ahb3_if
// Purpose  : Bundles everything one MSI master port exchanges with its AHB
//            master, the slave-port array and the slave-port arbiters.
// Modports : master - view of the master-port logic (mst* in, slv* out)
//            slave  - view of the surrounding fabric (drives mst*, slv* in)
// Revision : 1.0 - initial release
// ============================================================================
interface peripheral_msi_master_port_ahb3_if #(
  parameter int PLEN   = 64,
  parameter int XLEN   = 64,
  parameter int SLAVES = 5
);
  // AHB master side
  logic [2:0]                   mstpriority;
  logic                         mstHSEL;
  logic [PLEN-1:0]              mstHADDR;
  logic [XLEN-1:0]              mstHWDATA;
  logic                         mstHWRITE;
  logic [2:0]                   mstHSIZE;
  logic [2:0]                   mstHBURST;
  logic [3:0]                   mstHPROT;
  logic [1:0]                   mstHTRANS;
  logic                         mstHMASTLOCK;
  logic [XLEN-1:0]              mstHRDATA;
  logic                         mstHREADYOUT;
  logic                         mstHRESP;

  // Slave-port side
  logic [SLAVES-1:0][PLEN-1:0]  slvHADDR_MASK;
  logic [SLAVES-1:0][PLEN-1:0]  slvHADDR_BASE;
  logic [2:0]                   slvpriority;
  logic [SLAVES-1:0]            slvHSEL;
  logic [PLEN-1:0]              slvHADDR;
  logic [XLEN-1:0]              slvHWDATA;
  logic                         slvHWRITE;
  logic [2:0]                   slvHSIZE;
  logic [2:0]                   slvHBURST;
  logic [3:0]                   slvHPROT;
  logic [1:0]                   slvHTRANS;
  logic                         slvHMASTLOCK;
  logic                         slvHREADY;
  logic [SLAVES-1:0][XLEN-1:0]  slvHRDATA;
  logic [SLAVES-1:0]            slvHREADYOUT;
  logic [SLAVES-1:0]            slvHRESP;

  // Arbitration handshake
  logic [SLAVES-1:0]            granted;
  logic [SLAVES-1:0]            can_switch;

  modport master (
    input  mstpriority, mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE,
           mstHBURST, mstHPROT, mstHTRANS, mstHMASTLOCK,
    output mstHRDATA, mstHREADYOUT, mstHRESP,
    input  slvHADDR_MASK, slvHADDR_BASE,
    output slvpriority, slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE,
           slvHBURST, slvHPROT, slvHTRANS, slvHMASTLOCK, slvHREADY,
    input  slvHRDATA, slvHREADYOUT, slvHRESP, granted,
    output can_switch
  );

  modport slave (
    output mstpriority, mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE,
           mstHBURST, mstHPROT, mstHTRANS, mstHMASTLOCK,
    input  mstHRDATA, mstHREADYOUT, mstHRESP,
    output slvHADDR_MASK, slvHADDR_BASE,
    input  slvpriority, slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE,
           slvHBURST, slvHPROT, slvHTRANS, slvHMASTLOCK, slvHREADY,
    output slvHRDATA, slvHREADYOUT, slvHRESP, granted,
    input  can_switch
  );
endinterface
`default_nettype wire

// File: rtl/peripheral_msi_master_port_ahb3_decoder.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_msi_address_decoder_ahb3
// Purpose  : Combinational base/mask address decode. Produces a one-hot
//            select of the lowest-index matching slave port.
// Ports    : addr (in)  - master address
//            base/mask (in) - per-slave decode window
//            sel (out)  - one-hot select, zero when nothing matches
//            hit_any (out) - at least one window matched
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_msi_address_decoder_ahb3 #(
  parameter int PLEN   = 64,
  parameter int SLAVES = 5
) (
  input  logic [PLEN-1:0]             addr,
  input  logic [SLAVES-1:0][PLEN-1:0] base,
  input  logic [SLAVES-1:0][PLEN-1:0] mask,
  output logic [SLAVES-1:0]           sel,
  output logic                        hit_any
);

  logic [SLAVES-1:0] w_hit;

  always_comb begin
    w_hit = '0;
    for (int s = 0; s < SLAVES; s++) begin
      w_hit[s] = ((addr ^ base[s]) & mask[s]) == '0;
    end
  end

  // Isolate the lowest set bit: x & -x.
  assign sel     = w_hit & (~w_hit + {{(SLAVES-1){1'b0}}, 1'b1});
  assign hit_any = |w_hit;

endmodule
`default_nettype wire

// File: rtl/peripheral_msi_master_port_ahb3.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_msi_master_port_ahb3
// Purpose  : Per-master front end of the MSI AHB3-Lite interconnect. Decodes
//            the master address, requests the matching slave port, stalls
//            the master while that port serves another master, steers the
//            data phase back and tells the arbiters when they may switch.
// Ports    : HCLK   - clock
//            HRESET - synchronous active-high reset
//            bus    - master/slave-port/arbiter signal bundle (master modport)
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_msi_master_port_ahb3
  import peripheral_msi_ahb3_pkg::*;
#(
  parameter int PLEN   = 64,
  parameter int XLEN   = 64,
  parameter int SLAVES = 5
) (
  input  logic HCLK,
  input  logic HRESET,
  peripheral_msi_master_port_ahb3_if.master bus
);

  port_state_t       r_state, w_state_nxt;
  logic [SLAVES-1:0] r_data_slave;   // one-hot owner of the data phase, 0 = none
  logic [SLAVES-1:0] r_target;       // one-hot target of the buffered command
  logic [3:0]        r_burst_cnt;
  logic              r_incr_open, r_lock_hold;

  // Command buffer for a transfer that must wait for its grant.
  logic [PLEN-1:0]   r_haddr;
  logic              r_hwrite, r_hmastlock;
  logic [2:0]        r_hsize, r_hburst;
  logic [3:0]        r_hprot;
  logic [1:0]        r_htrans;

  logic [SLAVES-1:0] w_sel;
  logic              w_hit_any, w_active, w_accept, w_tgt_granted;
  logic              w_buf_granted, w_buf_ready, w_reissue, w_hold;
  logic              w_ready_out, w_resp_out;
  logic [XLEN-1:0]   w_dp_rdata;
  logic              w_dp_ready, w_dp_resp;

  peripheral_msi_address_decoder_ahb3 #(.PLEN(PLEN), .SLAVES(SLAVES)) u_decoder (
    .addr    (bus.mstHADDR),
    .base    (bus.slvHADDR_BASE),
    .mask    (bus.slvHADDR_MASK),
    .sel     (w_sel),
    .hit_any (w_hit_any)
  );

  assign w_active = bus.mstHSEL &&
                    (bus.mstHTRANS == HTRANS_NONSEQ || bus.mstHTRANS == HTRANS_SEQ);
  assign w_accept      = w_ready_out && w_active;
  assign w_tgt_granted = |(w_sel & bus.granted);
  assign w_buf_granted = |(r_target & bus.granted);
  assign w_buf_ready   = |(r_target & bus.slvHREADYOUT);
  assign w_reissue     = (r_state == ST_WAIT_GRANT) && w_buf_granted && w_buf_ready;

  // Data-phase return path; an idle data phase looks like a zero-wait OKAY.
  always_comb begin
    w_dp_rdata = '0;
    w_dp_ready = 1'b1;
    w_dp_resp  = 1'b0;
    for (int s = 0; s < SLAVES; s++) begin
      if (r_data_slave[s]) begin
        w_dp_rdata = bus.slvHRDATA[s];
        w_dp_ready = bus.slvHREADYOUT[s];
        w_dp_resp  = bus.slvHRESP[s];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= ST_NORMAL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ready_out      = w_dp_ready;
    w_resp_out       = w_dp_resp;
    bus.slvHSEL      = w_sel & {SLAVES{bus.mstHSEL}};
    bus.slvHADDR     = bus.mstHADDR;
    bus.slvHWRITE    = bus.mstHWRITE;
    bus.slvHSIZE     = bus.mstHSIZE;
    bus.slvHBURST    = bus.mstHBURST;
    bus.slvHPROT     = bus.mstHPROT;
    bus.slvHTRANS    = bus.mstHTRANS;
    bus.slvHMASTLOCK = bus.mstHMASTLOCK;
    case (r_state)
      ST_NORMAL, ST_ERR2: begin
        if (r_state == ST_ERR2) begin
          w_ready_out = 1'b1;
          w_resp_out  = 1'b1;
          w_state_nxt = ST_NORMAL;
        end
        if (w_accept) begin
          if (!w_hit_any)          w_state_nxt = ST_ERR1;
          else if (!w_tgt_granted) w_state_nxt = ST_WAIT_GRANT;
          else                     w_state_nxt = ST_NORMAL;
        end
      end
      ST_WAIT_GRANT: begin
        w_ready_out      = 1'b0;
        w_resp_out       = 1'b0;
        bus.slvHSEL      = r_target;
        bus.slvHADDR     = r_haddr;
        bus.slvHWRITE    = r_hwrite;
        bus.slvHSIZE     = r_hsize;
        bus.slvHBURST    = r_hburst;
        bus.slvHPROT     = r_hprot;
        bus.slvHMASTLOCK = r_hmastlock;
        // The slave port never saw the start of this burst, so a SEQ must
        // be presented to it as a fresh NONSEQ.
        if (!w_buf_granted)               bus.slvHTRANS = HTRANS_IDLE;
        else if (r_htrans == HTRANS_SEQ)  bus.slvHTRANS = HTRANS_NONSEQ;
        else                              bus.slvHTRANS = r_htrans;
        if (w_reissue) w_state_nxt = ST_NORMAL;
      end
      ST_ERR1: begin
        w_ready_out   = 1'b0;
        w_resp_out    = 1'b1;
        bus.slvHSEL   = '0;
        bus.slvHTRANS = HTRANS_IDLE;
        w_state_nxt   = ST_ERR2;
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_data_slave <= '0;
      r_target     <= '0;
      r_burst_cnt  <= '0;
      r_incr_open  <= 1'b0;
      r_lock_hold  <= 1'b0;
      r_haddr      <= '0;
      r_hwrite     <= 1'b0;
      r_hsize      <= '0;
      r_hburst     <= '0;
      r_hprot      <= '0;
      r_htrans     <= HTRANS_IDLE;
      r_hmastlock  <= 1'b0;
    end else begin
      if (w_ready_out) begin
        // An unlocked address phase (including IDLE) ends a locked sequence.
        r_lock_hold <= bus.mstHSEL & bus.mstHMASTLOCK;
        if (w_active) begin
          r_data_slave <= (w_hit_any && w_tgt_granted) ? w_sel : '0;
          if (w_hit_any && !w_tgt_granted) begin
            r_target    <= w_sel;
            r_haddr     <= bus.mstHADDR;
            r_hwrite    <= bus.mstHWRITE;
            r_hsize     <= bus.mstHSIZE;
            r_hburst    <= bus.mstHBURST;
            r_hprot     <= bus.mstHPROT;
            r_htrans    <= bus.mstHTRANS;
            r_hmastlock <= bus.mstHMASTLOCK;
          end
          if (bus.mstHTRANS == HTRANS_NONSEQ) begin
            r_burst_cnt <= burst_beats_left(bus.mstHBURST);
            r_incr_open <= (bus.mstHBURST == HBURST_INCR);
          end else if (r_burst_cnt != 4'd0) begin
            r_burst_cnt <= r_burst_cnt - 4'd1;
          end
        end else begin
          r_data_slave <= '0;
          if (!bus.mstHSEL || bus.mstHTRANS == HTRANS_IDLE) r_incr_open <= 1'b0;
        end
      end
      if (w_reissue) r_data_slave <= r_target;
      // An error from the slave aborts the burst; nothing left to protect.
      if (w_dp_resp) begin
        r_burst_cnt <= '0;
        r_incr_open <= 1'b0;
      end
    end
  end

  assign w_hold           = r_lock_hold | r_incr_open | (r_burst_cnt != 4'd0);
  assign bus.can_switch   = ~(r_data_slave & {SLAVES{w_hold}});
  assign bus.mstHRDATA    = w_dp_rdata;
  assign bus.mstHREADYOUT = w_ready_out;
  assign bus.mstHRESP     = w_resp_out;
  assign bus.slvHREADY    = w_ready_out;
  assign bus.slvHWDATA    = bus.mstHWDATA;
  assign bus.slvpriority  = bus.mstpriority;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_msi_master_port_ahb3.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_msi_master_port_ahb3
// Purpose  : Self-checking bench: a randomized AHB master with bursts and
//            locks, random slave-port responses and grants, occasional
//            resets, checked each cycle against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_msi_master_port_ahb3;
  import peripheral_msi_ahb3_pkg::*;

  localparam int PLEN   = 64;
  localparam int XLEN   = 64;
  localparam int SLAVES = 5;
  localparam int CYCLES = 4000;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  peripheral_msi_master_port_ahb3_if #(.PLEN(PLEN), .XLEN(XLEN), .SLAVES(SLAVES)) bus ();

  peripheral_msi_master_port_ahb3 #(.PLEN(PLEN), .XLEN(XLEN), .SLAVES(SLAVES)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- address map ----------------
  logic [PLEN-1:0] base_tab [SLAVES];
  logic [PLEN-1:0] mask_tab [SLAVES];
  int unsigned     blen [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  function automatic int decode(input logic [PLEN-1:0] a);
    for (int s = 0; s < SLAVES; s++)
      if (((a ^ base_tab[s]) & mask_tab[s]) == '0) return s;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [PLEN-1:0] addr;
    logic            write;
    logic [2:0]      size;
    logic [2:0]      burst;
    logic [3:0]      prot;
    logic [1:0]      trans;
    logic            lock;
    int              tgt;
  } cmd_t;

  int   owner;      // slave index owning the data phase, -1 none
  bit   stalled;    // a command is waiting for its grant
  cmd_t held;
  int   err_left;   // 2 = first error cycle pending, 1 = second
  int   beats;      // SEQ beats still expected in a fixed burst
  bit   incr_open;
  bit   lock_hold;

  logic              e_ready, e_resp, e_active;
  logic [XLEN-1:0]   e_rdata;
  logic [SLAVES-1:0] e_sel, e_cs;
  logic [1:0]        e_trans;
  cmd_t              e_cmd;

  task automatic model_reset();
    owner = -1; stalled = 0; err_left = 0; beats = 0; incr_open = 0; lock_hold = 0;
  endtask

  task automatic predict();
    int t;
    e_active = bus.mstHSEL && (bus.mstHTRANS == HTRANS_NONSEQ || bus.mstHTRANS == HTRANS_SEQ);
    e_sel = '0;
    e_cmd.addr = bus.mstHADDR;  e_cmd.write = bus.mstHWRITE; e_cmd.size = bus.mstHSIZE;
    e_cmd.burst = bus.mstHBURST; e_cmd.prot = bus.mstHPROT; e_cmd.lock = bus.mstHMASTLOCK;
    e_trans = bus.mstHTRANS;
    if (err_left == 2) begin
      e_ready = 0; e_resp = 1; e_rdata = '0; e_trans = HTRANS_IDLE;
    end else if (stalled) begin
      e_ready = 0; e_resp = 0; e_rdata = '0;
      e_sel[held.tgt] = 1'b1;
      e_cmd = held;
      if (!bus.granted[held.tgt])      e_trans = HTRANS_IDLE;
      else if (held.trans == HTRANS_SEQ) e_trans = HTRANS_NONSEQ;
      else                              e_trans = held.trans;
    end else begin
      if (err_left == 1) begin
        e_ready = 1; e_resp = 1; e_rdata = '0;
      end else if (owner >= 0) begin
        e_ready = bus.slvHREADYOUT[owner]; e_resp = bus.slvHRESP[owner]; e_rdata = bus.slvHRDATA[owner];
      end else begin
        e_ready = 1; e_resp = 0; e_rdata = '0;
      end
      t = decode(bus.mstHADDR);
      if (bus.mstHSEL && t >= 0) e_sel[t] = 1'b1;
    end
    e_cs = '1;
    if (owner >= 0 && (lock_hold || incr_open || beats != 0)) e_cs[owner] = 1'b0;
  endtask

  task automatic compare();
    check("HREADYOUT",  64'(bus.mstHREADYOUT), 64'(e_ready));
    check("HRESP",      64'(bus.mstHRESP),     64'(e_resp));
    check("HRDATA",     64'(bus.mstHRDATA),    64'(e_rdata));
    check("slvHREADY",  64'(bus.slvHREADY),    64'(e_ready));
    check("slvHSEL",    64'(bus.slvHSEL),      64'(e_sel));
    check("slvHTRANS",  64'(bus.slvHTRANS),    64'(e_trans));
    check("can_switch", 64'(bus.can_switch),   64'(e_cs));
    check("slvprio",    64'(bus.slvpriority),  64'(bus.mstpriority));
    if (!stalled) check("slvHWDATA", 64'(bus.slvHWDATA), 64'(bus.mstHWDATA));
    if (e_sel != '0) begin
      check("slvHADDR",  64'(bus.slvHADDR),     64'(e_cmd.addr));
      check("slvHWRITE", 64'(bus.slvHWRITE),    64'(e_cmd.write));
      check("slvHSIZE",  64'(bus.slvHSIZE),     64'(e_cmd.size));
      check("slvHBURST", 64'(bus.slvHBURST),    64'(e_cmd.burst));
      check("slvHPROT",  64'(bus.slvHPROT),     64'(e_cmd.prot));
      check("slvHLOCK",  64'(bus.slvHMASTLOCK), 64'(e_cmd.lock));
    end
  endtask

  task automatic model_step();
    int  t;
    bit  resp_seen;
    resp_seen = (err_left == 0) && !stalled && (owner >= 0) && bus.slvHRESP[owner];
    if (err_left == 2) begin
      err_left = 1;
    end else if (stalled) begin
      if (bus.granted[held.tgt] && bus.slvHREADYOUT[held.tgt]) begin
        stalled = 0;
        owner   = held.tgt;
      end
    end else if (e_ready) begin
      err_left  = 0;
      lock_hold = bus.mstHSEL & bus.mstHMASTLOCK;
      if (e_active) begin
        t = decode(bus.mstHADDR);
        if (t < 0) begin
          err_left = 2; owner = -1;
        end else if (bus.granted[t]) begin
          owner = t;
        end else begin
          owner = -1; stalled = 1;
          held.addr = bus.mstHADDR; held.write = bus.mstHWRITE; held.size = bus.mstHSIZE;
          held.burst = bus.mstHBURST; held.prot = bus.mstHPROT; held.trans = bus.mstHTRANS;
          held.lock = bus.mstHMASTLOCK; held.tgt = t;
        end
        if (bus.mstHTRANS == HTRANS_NONSEQ) begin
          beats     = int'(blen[bus.mstHBURST]) - 1;
          incr_open = (bus.mstHBURST == HBURST_INCR);
        end else if (beats > 0) begin
          beats--;
        end
      end else begin
        owner = -1;
        if (!bus.mstHSEL || bus.mstHTRANS == HTRANS_IDLE) incr_open = 0;
      end
    end
    if (resp_seen) begin beats = 0; incr_open = 0; end
  endtask

  // ---------------- stimulus ----------------
  bit prev_ready;
  int gen_left;

  task automatic drive_master();
    int r;
    if (!prev_ready) return;  // master holds its address phase while stalled
    bus.mstHWDATA   = {$urandom, $urandom};
    bus.mstpriority = 3'($urandom);
    if (gen_left > 0) begin
      bus.mstHSEL = 1'b1;
      if ($urandom_range(0, 5) == 0) bus.mstHTRANS = HTRANS_BUSY;
      else begin
        bus.mstHTRANS = HTRANS_SEQ;
        bus.mstHADDR  = bus.mstHADDR + 64'd8;
        gen_left--;
      end
    end else begin
      r = int'($urandom_range(0, 9));
      bus.mstHSEL      = (r != 0);
      bus.mstHMASTLOCK = ($urandom_range(0, 4) == 0);
      bus.mstHWRITE    = 1'($urandom);
      bus.mstHSIZE     = 3'($urandom_range(0, 3));
      bus.mstHPROT     = 4'($urandom);
      bus.mstHBURST    = 3'($urandom);
      bus.mstHADDR     = {$urandom, $urandom};
      bus.mstHADDR[15:12] = ($urandom_range(0, 9) != 0) ? 4'($urandom_range(0, 7))
                                                         : 4'($urandom_range(8, 15));
      bus.mstHADDR[2:0] = 3'd0;
      if (r < 3) bus.mstHTRANS = HTRANS_IDLE;
      else begin
        bus.mstHTRANS = HTRANS_NONSEQ;
        if (bus.mstHBURST == HBURST_INCR) gen_left = int'($urandom_range(0, 4));
        else gen_left = int'(blen[bus.mstHBURST]) - 1;
      end
    end
  endtask

  task automatic drive_slaves();
    for (int s = 0; s < SLAVES; s++) begin
      bus.slvHRDATA[s]    = {$urandom, $urandom};
      bus.slvHREADYOUT[s] = ($urandom_range(0, 99) < 85);
      bus.slvHRESP[s]     = ($urandom_range(0, 19) == 0);
      bus.granted[s]      = ($urandom_range(0, 9) < 7);
    end
  endtask

  initial begin
    // slaves 0..3: 4 KiB windows at s*0x1000; slave 4 covers 0x0000-0x7FFF
    // and so only wins for 0x4000-0x7FFF; 0x8000-0xFFFF hits nothing.
    for (int s = 0; s < 4; s++) begin
      base_tab[s] = 64'(s) << 12;
      mask_tab[s] = 64'h0000_0000_0000_F000;
    end
    base_tab[4] = 64'h0;
    mask_tab[4] = 64'h0000_0000_0000_8000;
    for (int s = 0; s < SLAVES; s++) begin
      bus.slvHADDR_BASE[s] = base_tab[s];
      bus.slvHADDR_MASK[s] = mask_tab[s];
    end
    bus.mstpriority = 3'd0; bus.mstHSEL = 1'b0; bus.mstHADDR = '0; bus.mstHWDATA = '0;
    bus.mstHWRITE = 1'b0; bus.mstHSIZE = HSIZE_B64; bus.mstHBURST = HBURST_SINGLE;
    bus.mstHPROT = 4'h0; bus.mstHTRANS = HTRANS_IDLE; bus.mstHMASTLOCK = 1'b0;
    drive_slaves();
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    model_reset();
    @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    check("rst_HREADYOUT",  64'(bus.mstHREADYOUT), 64'd1);
    check("rst_HRESP",      64'(bus.mstHRESP),     64'd0);
    check("rst_HRDATA",     64'(bus.mstHRDATA),    64'd0);
    check("rst_slvHSEL",    64'(bus.slvHSEL),      64'd0);
    check("rst_can_switch", 64'(bus.can_switch),   64'h1F);

    prev_ready = 1;
    gen_left   = 0;
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge HCLK);
      drive_master();
      drive_slaves();
      HRESET = (stalled && $urandom_range(0, 4) == 0) || ($urandom_range(0, 399) == 0);
      #1;
      predict();
      compare();
      @(posedge HCLK);
      if (HRESET) begin
        model_reset();
        prev_ready = 1;
        gen_left   = 0;
      end else begin
        model_step();
        prev_ready = e_ready;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
